// File: rtl/jtag_host_ctrl_pkg.sv
// ============================================================================
// Module : jtag_host_ctrl_pkg
// Brief  : Shared encodings for the JTAG host: command opcodes, FSM states,
//          and the test-logic-reset sequence length.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package jtag_host_ctrl_pkg;

    localparam logic [1:0] c_op_tlr_reset = 2'b00;
    localparam logic [1:0] c_op_run_idle  = 2'b01;
    localparam logic [1:0] c_op_shift_ir  = 2'b10;
    localparam logic [1:0] c_op_shift_dr  = 2'b11;

    // TCK rises with TMS=1 that force any TAP into Test-Logic-Reset
    localparam int c_tlr_len = 5;

    typedef enum logic [3:0] {
        ST_INIT_TLR = 4'd0,
        ST_IDLE     = 4'd1,
        ST_RUN      = 4'd2,
        ST_SEL_DR   = 4'd3,
        ST_SEL_IR   = 4'd4,
        ST_CAPTURE  = 4'd5,
        ST_SHIFT    = 4'd6,
        ST_EXIT1    = 4'd7,
        ST_UPDATE   = 4'd8,
        ST_RSP      = 4'd9
    } state_t;

endpackage

`default_nettype wire

// File: rtl/jtag_host_ctrl_tck.sv
// ============================================================================
// Module : jtag_host_tck_gen
// Brief  : TCK divider. Toggles TCK every CLK_DIV clocks while enabled and
//          flags the clock cycle whose closing edge makes TCK rise or fall.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module jtag_host_tck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_tck,
    output logic o_rise,
    output logic o_fall
);

    localparam int c_cnt_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_tck;
    logic               w_wrap;

    assign w_wrap = i_en && (r_cnt == c_cnt_w'(CLK_DIV - 1));

    // Disabling restarts the divider so the next enabled phase is a full low half-period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_tck <= 1'b0;
        end else if (!i_en) begin
            r_cnt <= '0;
            r_tck <= 1'b0;
        end else if (w_wrap) begin
            r_cnt <= '0;
            r_tck <= ~r_tck;
        end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    assign o_tck  = r_tck;
    assign o_rise = w_wrap & ~r_tck;
    assign o_fall = w_wrap &  r_tck;

endmodule

`default_nettype wire

// File: rtl/jtag_host_ctrl.sv
// ============================================================================
// Module : jtag_host_ctrl
// Brief  : JTAG TAP host. Converts TLR/RUN/SHIFT_IR/SHIFT_DR commands into
//          TCK/TMS/TDI activity and returns captured TDO.
//          Optional macro JTAG_HOST_TRST_EN adds the trst_n pin.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module jtag_host_ctrl
    import jtag_host_ctrl_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int MAX_LEN = 64,
    parameter int LEN_W   = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_val,
    output logic               cmd_rdy,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_val,
    input  logic               rsp_rdy,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
`ifdef JTAG_HOST_TRST_EN
    output logic               trst_n,
`endif
    input  logic               tdo
);

    state_t             r_state;
    logic               r_tck_en;
    logic               r_tms;
    logic               r_tdi;
    logic               r_cmd_rdy;
    logic               r_rsp_val;
    logic               r_is_ir;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_cnt;
    logic [MAX_LEN-1:0] r_sr;
    logic [MAX_LEN-1:0] r_cap;
    logic [MAX_LEN-1:0] r_rsp_data;
    logic               w_tck;
    logic               w_rise;
    logic               w_fall;
    logic               w_fire;
    logic [LEN_W-1:0]   w_len_sat;

`ifdef JTAG_HOST_TRST_EN
    localparam int c_trst_clks = 4 * CLK_DIV;
    logic        r_trst_n;
    logic [15:0] r_wait;
`endif

    jtag_host_tck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tck_gen (
        .clk    (clk),
        .rst    (rst),
        .i_en   (r_tck_en),
        .o_tck  (w_tck),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    assign w_fire    = cmd_val & r_cmd_rdy;
    assign w_len_sat = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;

    // Each state covers whole TCK periods; TMS/TDI for the next period are
    // loaded on the fall strobe so they only ever move with TCK's falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_INIT_TLR;
            r_tms      <= 1'b1;
            r_tdi      <= 1'b0;
            r_cmd_rdy  <= 1'b0;
            r_rsp_val  <= 1'b0;
            r_rsp_data <= '0;
            r_is_ir    <= 1'b0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_sr       <= '0;
            r_cap      <= '0;
`ifdef JTAG_HOST_TRST_EN
            r_tck_en   <= 1'b0;
            r_trst_n   <= 1'b0;
            r_wait     <= '0;
`else
            r_tck_en   <= 1'b1;
`endif
        end else begin
            case (r_state)
                ST_INIT_TLR: begin
`ifdef JTAG_HOST_TRST_EN
                    if (!r_trst_n) begin
                        if (r_wait == 16'(c_trst_clks - 1)) begin
                            r_trst_n <= 1'b1;
                            r_tck_en <= 1'b1;
                            r_wait   <= '0;
                        end else begin
                            r_wait <= r_wait + 16'd1;
                        end
                    end else
`endif
                    if (w_fall) begin
                        if (r_cnt == LEN_W'(c_tlr_len)) begin
                            r_tck_en  <= 1'b0;
                            r_cnt     <= '0;
                            r_cmd_rdy <= 1'b1;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt + LEN_W'(1);
                            r_tms <= (r_cnt != LEN_W'(c_tlr_len - 1));
                        end
                    end
                end

                ST_IDLE: begin
                    if (w_fire) begin
                        r_cnt <= '0;
                        case (cmd_op)
                            c_op_tlr_reset: begin
                                r_tms     <= 1'b1;
                                r_cmd_rdy <= 1'b0;
                                r_state   <= ST_INIT_TLR;
`ifdef JTAG_HOST_TRST_EN
                                r_trst_n  <= 1'b0;
                                r_wait    <= '0;
                                r_tck_en  <= 1'b0;
`else
                                r_tck_en  <= 1'b1;
`endif
                            end
                            c_op_run_idle: begin
                                if (cmd_len != '0) begin
                                    r_len     <= cmd_len;
                                    r_tms     <= 1'b0;
                                    r_tck_en  <= 1'b1;
                                    r_cmd_rdy <= 1'b0;
                                    r_state   <= ST_RUN;
                                end
                            end
                            default: begin
                                r_is_ir   <= (cmd_op == c_op_shift_ir);
                                r_len     <= w_len_sat;
                                r_sr      <= cmd_data;
                                r_cap     <= '0;
                                r_cmd_rdy <= 1'b0;
                                if (w_len_sat == '0) begin
                                    r_rsp_val  <= 1'b1;
                                    r_rsp_data <= '0;
                                    r_state    <= ST_RSP;
                                end else begin
                                    r_tms    <= 1'b1;
                                    r_tck_en <= 1'b1;
                                    r_state  <= ST_SEL_DR;
                                end
                            end
                        endcase
                    end
                end

                ST_RUN: begin
                    if (w_fall) begin
                        if (r_cnt == r_len - LEN_W'(1)) begin
                            r_tck_en  <= 1'b0;
                            r_cmd_rdy <= 1'b1;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt + LEN_W'(1);
                        end
                    end
                end

                ST_SEL_DR: begin
                    if (w_fall) begin
                        if (r_is_ir) begin
                            r_state <= ST_SEL_IR;
                        end else begin
                            r_tms   <= 1'b0;
                            r_state <= ST_CAPTURE;
                        end
                    end
                end

                ST_SEL_IR: begin
                    if (w_fall) begin
                        r_tms   <= 1'b0;
                        r_state <= ST_CAPTURE;
                    end
                end

                // Two TMS=0 periods: Select->Capture, then Capture->Shift
                ST_CAPTURE: begin
                    if (w_fall) begin
                        if (r_cnt == '0) begin
                            r_cnt <= LEN_W'(1);
                        end else begin
                            r_cnt   <= '0;
                            r_tms   <= (r_len == LEN_W'(1));
                            r_tdi   <= r_sr[0];
                            r_state <= ST_SHIFT;
                        end
                    end
                end

                ST_SHIFT: begin
                    if (w_rise) begin
                        for (int i = 0; i < MAX_LEN; i++) begin
                            if (r_cnt == LEN_W'(i)) begin
                                r_cap[i] <= tdo;
                            end
                        end
                    end
                    if (w_fall) begin
                        if (r_cnt == r_len - LEN_W'(1)) begin
                            r_tms   <= 1'b1;
                            r_tdi   <= 1'b0;
                            r_state <= ST_EXIT1;
                        end else begin
                            r_cnt <= r_cnt + LEN_W'(1);
                            r_sr  <= r_sr >> 1;
                            r_tdi <= r_sr[1];
                            r_tms <= (r_cnt + LEN_W'(2) == r_len);
                        end
                    end
                end

                ST_EXIT1: begin
                    if (w_fall) begin
                        r_tms   <= 1'b0;
                        r_state <= ST_UPDATE;
                    end
                end

                ST_UPDATE: begin
                    if (w_rise) begin
                        r_rsp_val  <= 1'b1;
                        r_rsp_data <= r_cap;
                        r_state    <= ST_RSP;
                    end
                end

                // Leave only once the response is taken and TCK has parked low
                ST_RSP: begin
                    if (w_fall) begin
                        r_tck_en <= 1'b0;
                    end
                    if (r_rsp_val && rsp_rdy) begin
                        r_rsp_val <= 1'b0;
                    end
                    if ((!r_rsp_val || rsp_rdy) && (!r_tck_en || w_fall)) begin
                        r_cmd_rdy <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end

                default: begin
                    r_tck_en  <= 1'b0;
                    r_cmd_rdy <= 1'b1;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_rdy  = r_cmd_rdy;
    assign busy     = ~r_cmd_rdy;
    assign rsp_val  = r_rsp_val;
    assign rsp_data = r_rsp_data;
    assign tck      = w_tck;
    assign tms      = r_tms;
    assign tdi      = r_tdi;
`ifdef JTAG_HOST_TRST_EN
    assign trst_n   = r_trst_n;
`endif

endmodule

`default_nettype wire

// File: tb/tb_jtag_host_ctrl.sv
// ============================================================================
// Module : tb_jtag_host_ctrl
// Brief  : Directed bench for jtag_host_ctrl against a behavioural 8-bit-IR
//          TAP (IDCODE / BYPASS). Honours JTAG_HOST_TRST_EN when defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_jtag_host_ctrl;

    localparam logic [31:0] c_idcode    = 32'h4BA0_0477;
    localparam logic [7:0]  c_ir_idcode = 8'hFE;
    localparam int          S_TLR = 0, S_RTI = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_val = 1'b0;
    logic        cmd_rdy;
    logic [1:0]  cmd_op = 2'b00;
    logic [6:0]  cmd_len = 7'd0;
    logic [63:0] cmd_data = 64'd0;
    logic        rsp_val;
    logic        rsp_rdy = 1'b0;
    logic [63:0] rsp_data;
    logic        busy, tck, tms, tdi;
    logic        tdo = 1'b0;
    logic        m_trst_n;
`ifdef JTAG_HOST_TRST_EN
    logic        trst_n;
    assign m_trst_n = trst_n;
`else
    assign m_trst_n = 1'b1;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    jtag_host_ctrl #(.CLK_DIV(2), .MAX_LEN(64), .LEN_W(7)) dut (
        .clk(clk), .rst(rst),
        .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_val(rsp_val), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data), .busy(busy),
        .tck(tck), .tms(tms), .tdi(tdi),
`ifdef JTAG_HOST_TRST_EN
        .trst_n(trst_n),
`endif
        .tdo(tdo)
    );

    // Behavioural TAP: state moves and shifts on TCK rise, TDO launched on fall
    int          m_state = S_TLR;
    logic [7:0]  m_ir = c_ir_idcode;
    logic [7:0]  m_ir_sr = 8'd0;
    logic [31:0] m_dr = 32'd0;
    logic        m_byp = 1'b0;

    function automatic int tap_next(input int s, input logic t);
        case (s)
            0:  return t ? 0  : 1;
            1:  return t ? 2  : 1;
            2:  return t ? 9  : 3;
            3:  return t ? 5  : 4;
            4:  return t ? 5  : 4;
            5:  return t ? 8  : 6;
            6:  return t ? 7  : 6;
            7:  return t ? 8  : 4;
            8:  return t ? 2  : 1;
            9:  return t ? 0  : 10;
            10: return t ? 12 : 11;
            11: return t ? 12 : 11;
            12: return t ? 15 : 13;
            13: return t ? 14 : 13;
            14: return t ? 15 : 11;
            15: return t ? 2  : 1;
            default: return 0;
        endcase
    endfunction

    always @(posedge tck or negedge m_trst_n) begin
        if (!m_trst_n) begin
            m_state <= S_TLR;
            m_ir    <= c_ir_idcode;
        end else begin
            case (m_state)
                3:  if (m_ir == c_ir_idcode) m_dr <= c_idcode; else m_byp <= 1'b0;
                4:  if (m_ir == c_ir_idcode) m_dr <= {tdi, m_dr[31:1]}; else m_byp <= tdi;
                10: m_ir_sr <= 8'h01;
                11: m_ir_sr <= {tdi, m_ir_sr[7:1]};
                15: m_ir <= m_ir_sr;
                default: ;
            endcase
            m_state <= tap_next(m_state, tms);
            if (tap_next(m_state, tms) == S_TLR) m_ir <= c_ir_idcode;
        end
    end

    always @(negedge tck) begin
        if (m_state == 4)       tdo <= (m_ir == c_ir_idcode) ? m_dr[0] : m_byp;
        else if (m_state == 11) tdo <= m_ir_sr[0];
        else                    tdo <= 1'b0;
    end

    // Pin monitors
    int          rises = 0, falls = 0, viol = 0, rsp_seen = 0, trst_lo = 0;
    logic [63:0] tms_log = 64'd0;
    logic        p_tms = 1'b1, p_tdi = 1'b0;

    always @(posedge tck) begin
        rises   <= rises + 1;
        tms_log <= {tms_log[62:0], tms};
    end
    always @(negedge tck) falls <= falls + 1;
    always @(negedge clk) begin
        if (tck === 1'b1 && (tms !== p_tms || tdi !== p_tdi)) viol <= viol + 1;
        p_tms <= tms;
        p_tdi <= tdi;
        if (rsp_val === 1'b1) rsp_seen <= rsp_seen + 1;
`ifdef JTAG_HOST_TRST_EN
        if (trst_n === 1'b0) trst_lo <= trst_lo + 1;
`endif
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_rdy(input string tag);
        int n = 0;
        while (cmd_rdy !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        chk(tag, cmd_rdy, 1);
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        while (rsp_val !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        chk(tag, rsp_val, 1);
    endtask

    task automatic send(input logic [1:0] op, input logic [6:0] len, input logic [63:0] data);
        wait_rdy("send_rdy");
        cmd_val  = 1'b1;
        cmd_op   = op;
        cmd_len  = len;
        cmd_data = data;
        @(negedge clk);
        cmd_val  = 1'b0;
        cmd_op   = 2'($urandom);
        cmd_len  = 7'($urandom);
        cmd_data = {$urandom, $urandom};
    endtask

    task automatic consume();
        rsp_rdy = 1'b1;
        @(negedge clk);
        rsp_rdy = 1'b0;
        chk("rsp_drop", rsp_val, 0);
    endtask

    initial begin
        int r0, f0, s0, t0, n;
        logic hold_ok;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_tck", tck, 0);
        chk("rst_tms", tms, 1);
        chk("rst_tdi", tdi, 0);
        chk("rst_cmd_rdy", cmd_rdy, 0);
        chk("rst_rsp_val", rsp_val, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_busy", busy, 1);
`ifdef JTAG_HOST_TRST_EN
        chk("rst_trst_n", trst_n, 0);
`endif

        // Automatic TLR after reset release
        r0 = rises;
        rst = 1'b0;
        wait_rdy("init_rdy");
        chk("init_rises", rises - r0, 6);
        chk("init_tms_seq", tms_log[5:0], 6'b111110);
        chk("init_tck_low", tck, 0);
        chk("init_busy", busy, 0);
        chk("init_tap_rti", m_state, S_RTI);

        // IDCODE read straight after reset
        r0 = rises; f0 = falls;
        send(2'b11, 7'd32, 64'd0);
        wait_rsp("idcode_rsp");
        chk("idcode_data", rsp_data, {32'd0, c_idcode});
        chk("idcode_periods", rises - r0, 37);
        consume();
        wait_rdy("idcode_done");
        chk("idcode_falls", falls - f0, 37);
        chk("idcode_tap_rti", m_state, S_RTI);

        // Load BYPASS; hold response for 20 clocks
        r0 = rises;
        send(2'b10, 7'd8, 64'hFF);
        wait_rsp("ir_rsp");
        chk("ir_periods", rises - r0, 14);
        repeat (4) @(negedge clk);
        r0 = rises; f0 = falls;
        hold_ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (rsp_val !== 1'b1 || rsp_data !== 64'h01 || cmd_rdy !== 1'b0) hold_ok = 1'b0;
        end
        chk("hold_stable", hold_ok, 1);
        chk("hold_no_tck", (rises - r0) + (falls - f0), 0);
        consume();
        chk("ir_loaded", m_ir, 8'hFF);

        // One-bit bypass delay
        r0 = rises;
        send(2'b11, 7'd9, 64'h1AB);
        wait_rsp("byp_rsp");
        chk("byp_data", rsp_data, 64'h156);
        chk("byp_periods", rises - r0, 14);
        consume();

        // RUN_IDLE zero and three
        wait_rdy("run0_pre");
        r0 = rises; f0 = falls;
        send(2'b01, 7'd0, 64'd0);
        repeat (10) @(negedge clk);
        chk("run0_no_tck", (rises - r0) + (falls - f0), 0);
        chk("run0_rdy", cmd_rdy, 1);
        r0 = rises;
        send(2'b01, 7'd3, 64'd0);
        wait_rdy("run3_done");
        chk("run3_rises", rises - r0, 3);
        chk("run3_tms", tms_log[2:0], 3'b000);
        chk("run3_tap_rti", m_state, S_RTI);

        // Zero-length shift
        r0 = rises; f0 = falls;
        send(2'b11, 7'd0, 64'hDEAD_BEEF);
        chk("len0_rsp_val", rsp_val, 1);
        chk("len0_rsp_data", rsp_data, 0);
        consume();
        chk("len0_no_tck", (rises - r0) + (falls - f0), 0);

        // Over-length saturates to 64 bits through bypass
        r0 = rises;
        send(2'b11, 7'd100, 64'hF0E1_D2C3_B4A5_9687);
        wait_rsp("sat_rsp");
        chk("sat_data", rsp_data, 64'hE1C3_A587_694B_2D0E);
        chk("sat_periods", rises - r0, 69);
        consume();

        // TLR_RESET command restores IDCODE instruction
        r0 = rises; t0 = trst_lo;
        send(2'b00, 7'd0, 64'd0);
        wait_rdy("tlr_done");
        chk("tlr_rises", rises - r0, 6);
        chk("tlr_tms_seq", tms_log[5:0], 6'b111110);
        chk("tlr_tap_rti", m_state, S_RTI);
        chk("tlr_ir_idcode", m_ir, c_ir_idcode);
`ifdef JTAG_HOST_TRST_EN
        chk("tlr_trst_clks", trst_lo - t0, 8);
`endif

        // Reset during bit 10 of a DR shift
        r0 = rises;
        send(2'b11, 7'd32, 64'd0);
        n = 0;
        while (rises < r0 + 14 && n < 1000) begin @(negedge clk); n++; end
        chk("mid_reached_bit10", rises - r0, 14);
        rst = 1'b1;
        #1;
        chk("mid_tck", tck, 0);
        chk("mid_tms", tms, 1);
        chk("mid_cmd_rdy", cmd_rdy, 0);
        s0 = rsp_seen;
        repeat (3) @(negedge clk);
        r0 = rises;
        rst = 1'b0;
        wait_rdy("mid_init_rdy");
        chk("mid_init_rises", rises - r0, 6);
        chk("mid_no_rsp", rsp_seen - s0, 0);
        chk("mid_tap_rti", m_state, S_RTI);

        chk("pins_stable_tck_high", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
